// File: rtl/uram_bist_pkg.sv
// Shared types and constants for the URAM BIST controller.
package uram_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } bist_state_e;

  typedef enum logic [1:0] {
    MODE_COUNT = 2'd0,
    MODE_INV   = 2'd1,
    MODE_LFSR  = 2'd2,
    MODE_RSVD  = 2'd3
  } bist_mode_e;

  // Right-shifting Galois form of x^32+x^22+x^2+x+1
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam int          ERR_W     = 32;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_POLY) : (v >> 1);
  endfunction

endpackage

// File: rtl/uram_bist_pattern.sv
// Sequential pattern source: holds pattern(k), advanced once per word.
// LFSR mode exists only when URAM_BIST_LFSR_EN is defined.
module uram_bist_pattern
  import uram_bist_pkg::*;
#(
  parameter int DATA_WIDTH = 72
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  adv,
  input  logic [31:0]           seed,
  input  bist_mode_e            mode,
  output logic [DATA_WIDTH-1:0] data
);

  bist_mode_e            mode_q;
  logic [31:0]           cnt;
  logic [DATA_WIDTH-1:0] count_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= MODE_COUNT;
      cnt    <= '0;
    end else if (load) begin
      mode_q <= mode;
      cnt    <= seed;
    end else if (adv) begin
      cnt    <= cnt + 32'd1;
    end
  end

  assign count_w = DATA_WIDTH'(cnt);

`ifdef URAM_BIST_LFSR_EN
  localparam int REP = (DATA_WIDTH + 31) / 32;

  logic [31:0]           lfsr;
  logic [DATA_WIDTH-1:0] lfsr_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       lfsr <= 32'd1;
    else if (load) lfsr <= (seed == 32'd0) ? 32'd1 : seed;
    else if (adv)  lfsr <= lfsr_step(lfsr);
  end

  assign lfsr_w = DATA_WIDTH'({REP{lfsr}});

  always_comb begin
    data = count_w;
    case (mode_q)
      MODE_INV:  data = ~count_w;
      MODE_LFSR: data = lfsr_w;
      default:   data = count_w;
    endcase
  end
`else
  // Mode 2 (and reserved 3) fall back to the count pattern
  always_comb begin
    data = count_w;
    if (mode_q == MODE_INV) data = ~count_w;
  end
`endif

endmodule

// File: rtl/uram_bist_ctrl.sv
// URAM BIST controller: write pass, read/compare pass, error capture.
// Optional LFSR pattern via URAM_BIST_LFSR_EN.
module uram_bist_ctrl
  import uram_bist_pkg::*;
#(
  parameter  int DATA_WIDTH = 72,
  parameter  int DATA_DEPTH = 4096,
  parameter  int RD_LATENCY = 2,
  localparam int AW         = $clog2(DATA_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [1:0]            mode,
  input  logic [31:0]           seed,
  output logic                  wea,
  output logic [AW-1:0]         addra,
  output logic [DATA_WIDTH-1:0] dina,
  output logic [AW-1:0]         addrb,
  input  logic [DATA_WIDTH-1:0] doutb,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_W-1:0]      err_cnt,
  output logic [AW-1:0]         first_err_addr
);

  bist_state_e state, state_nxt;

  logic                         accept, abort_run, rd_issue;
  logic                         wr_last, rd_last, drn_last;
  logic [2:0]                   drn_cnt;
  logic [RD_LATENCY:1]          vld_pipe;
  logic [RD_LATENCY:1][AW-1:0]  adr_pipe;
  logic [DATA_WIDTH-1:0]        exp_data;
  logic                         cmp_vld, mism;
  logic [ERR_W-1:0]             err_nxt;

  assign accept    = (state == ST_IDLE) && start && !abort;
  assign abort_run = (state != ST_IDLE) && abort;
  assign wr_last   = (addra == AW'(DATA_DEPTH - 1));
  assign rd_last   = (addrb == AW'(DATA_DEPTH - 1));
  assign drn_last  = (drn_cnt == 3'(RD_LATENCY - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wea       = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    rd_issue  = 1'b0;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_WRITE;
      ST_WRITE: begin
        wea  = 1'b1;
        busy = 1'b1;
        if (abort)        state_nxt = ST_IDLE;
        else if (wr_last) state_nxt = ST_READ;
      end
      ST_READ: begin
        busy     = 1'b1;
        rd_issue = 1'b1;
        if (abort)        state_nxt = ST_IDLE;
        else if (rd_last) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (abort)         state_nxt = ST_IDLE;
        else if (drn_last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Write-side and expected-side generators run the same sequence,
  // each advanced by its own consumer.
  uram_bist_pattern #(.DATA_WIDTH(DATA_WIDTH)) u_wr_pat (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .adv  (wea),
    .seed (seed),
    .mode (bist_mode_e'(mode)),
    .data (dina)
  );

  uram_bist_pattern #(.DATA_WIDTH(DATA_WIDTH)) u_exp_pat (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .adv  (cmp_vld),
    .seed (seed),
    .mode (bist_mode_e'(mode)),
    .data (exp_data)
  );

  assign cmp_vld = vld_pipe[RD_LATENCY];
  assign mism    = cmp_vld && (doutb != exp_data);
  assign err_nxt = (mism && !(&err_cnt)) ? err_cnt + ERR_W'(1) : err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addra          <= '0;
      addrb          <= '0;
      drn_cnt        <= '0;
      vld_pipe       <= '0;
      adr_pipe       <= '0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      pass           <= 1'b0;
    end else if (accept) begin
      addra          <= '0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      pass           <= 1'b0;
    end else if (abort_run) begin
      // Results so far stay visible; in-flight reads are discarded
      pass     <= 1'b0;
      vld_pipe <= '0;
    end else begin
      if (state == ST_WRITE) begin
        if (!wr_last) addra <= addra + AW'(1);
        else          addrb <= '0;
      end
      if (state == ST_READ) begin
        if (!rd_last) addrb   <= addrb + AW'(1);
        else          drn_cnt <= '0;
      end
      if (state == ST_DRAIN) drn_cnt <= drn_cnt + 3'd1;

      vld_pipe[1] <= rd_issue;
      adr_pipe[1] <= addrb;
      for (int i = 2; i <= RD_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        adr_pipe[i] <= adr_pipe[i-1];
      end

      err_cnt <= err_nxt;
      if (mism && (err_cnt == '0)) first_err_addr <= adr_pipe[RD_LATENCY];
      // The final compare lands on the DRAIN->DONE edge, so use err_nxt
      if ((state == ST_DRAIN) && drn_last) pass <= (err_nxt == '0);
    end
  end

endmodule
